// File: rtl/speed_select_ctrl.sv
// Speed select controller: debounces the speed switches and sequences the clock-mux select.
// The clock is gated off before every select change and kept off until the new clock settles.
// Define SPEED_CTRL_STATUS_EN to build a saturating count of completed select changes.
module speed_select_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int GATE_CYCLES     = 8,
    parameter int SETTLE_CYCLES   = 64
) (
    input  logic       clk_100mhz,
    input  logic       rst,
    input  logic [1:0] sw,
    input  logic       locked,
    output logic [1:0] sel,
    output logic       clk_en,
    output logic       busy,
    output logic [7:0] switch_count
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DEB_W-1:0] DEB_SAT = DEB_W'(DEBOUNCE_CYCLES);
    // The load cycle and the first matching cycle both count as stable time,
    // so acceptance happens two counts short of DEBOUNCE_CYCLES.
    localparam logic [DEB_W-1:0] DEB_THRESH =
        DEB_W'((DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0);

    localparam int CNT_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_LOCK,
        SETTLE,
        RUN,
        GATE_OFF,
        SWITCH
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         sw_meta;
    logic [1:0]         sw_sync;
    logic               lock_meta;
    logic               lock_sync;
    logic [1:0]         candidate;
    logic [1:0]         sw_stable;
    logic [DEB_W-1:0]   deb_cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the values from before the edge and the two synchronizer stages stay distinct.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            sw_meta   <= 2'b00;
            sw_sync   <= 2'b00;
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            sw_meta   <= sw;
            sw_sync   <= sw_meta;
            lock_meta <= locked;
            lock_sync <= lock_meta;
        end
    end

    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            candidate <= 2'b00;
            deb_cnt   <= '0;
            sw_stable <= 2'b00;
        end else if (sw_sync != candidate) begin
            candidate <= sw_sync;
            deb_cnt   <= '0;
        end else begin
            if (deb_cnt != DEB_SAT) begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
            if (deb_cnt >= DEB_THRESH) begin
                sw_stable <= candidate;
            end
        end
    end

    // Outputs are registered from the next state, so clk_en and busy track the state exactly.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            state  <= WAIT_LOCK;
            cnt    <= '0;
            sel    <= 2'b00;
            clk_en <= 1'b0;
            busy   <= 1'b1;
        end else if (!lock_sync && state != WAIT_LOCK) begin
            state  <= WAIT_LOCK;
            clk_en <= 1'b0;
            busy   <= 1'b1;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    clk_en <= 1'b0;
                    busy   <= 1'b1;
                    if (lock_sync) begin
                        state <= SETTLE;
                        cnt   <= SETTLE_LOAD;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        if (sw_stable != sel) begin
                            state <= SWITCH;
                        end else begin
                            state  <= RUN;
                            clk_en <= (sel != 2'b00);
                            busy   <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RUN: begin
                    if (sw_stable != sel) begin
                        state  <= GATE_OFF;
                        cnt    <= GATE_LOAD;
                        clk_en <= 1'b0;
                        busy   <= 1'b1;
                    end else begin
                        clk_en <= (sel != 2'b00);
                    end
                end
                GATE_OFF: begin
                    if (cnt == '0) begin
                        state <= SWITCH;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                SWITCH: begin
                    sel   <= sw_stable;
                    state <= SETTLE;
                    cnt   <= SETTLE_LOAD;
                end
                default: begin
                    state  <= WAIT_LOCK;
                    clk_en <= 1'b0;
                    busy   <= 1'b1;
                end
            endcase
        end
    end

`ifdef SPEED_CTRL_STATUS_EN
    logic [7:0] switch_cnt_q;

    // Only a SWITCH cycle that survives the lock check and really moves sel is counted.
    always_ff @(posedge clk_100mhz or posedge rst) begin
        if (rst) begin
            switch_cnt_q <= 8'd0;
        end else if (state == SWITCH && lock_sync && sw_stable != sel
                     && switch_cnt_q != 8'hFF) begin
            switch_cnt_q <= switch_cnt_q + 8'd1;
        end
    end

    assign switch_count = switch_cnt_q;
`else
    assign switch_count = 8'd0;
`endif

endmodule

// File: tb/tb_speed_select_ctrl.sv
// Self-checking bench for speed_select_ctrl with short debounce/gate/settle times.
// A monitor pops expected sel values from a scoreboard queue on every observed sel change.
`timescale 1ns/1ps
module tb_speed_select_ctrl;

    localparam int DEB    = 4;
    localparam int GATE   = 2;
    localparam int SETTLE = 3;

    logic       clk_100mhz = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] sw = 2'b00;
    logic       locked = 1'b0;
    logic [1:0] sel;
    logic       clk_en;
    logic       busy;
    logic [7:0] switch_count;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_sel_q[$];
    logic [7:0] exp_count = 8'd0;
    logic [1:0] prev_sel = 2'b00;
    logic       prev_clk_en = 1'b0;

    speed_select_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .GATE_CYCLES    (GATE),
        .SETTLE_CYCLES  (SETTLE)
    ) dut (
        .clk_100mhz  (clk_100mhz),
        .rst         (rst),
        .sw          (sw),
        .locked      (locked),
        .sel         (sel),
        .clk_en      (clk_en),
        .busy        (busy),
        .switch_count(switch_count)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard consumer: every sel change must match the next queued value,
    // and clk_en must not move in the same cycle.
    always @(negedge clk_100mhz) begin
        if (sel !== prev_sel) begin
            checks++;
            if (exp_sel_q.size() == 0) begin
                errors++;
                $display("FAIL sel_unexpected: sel changed %b -> %b with nothing expected", prev_sel, sel);
            end else begin
                logic [1:0] exp;
                exp = exp_sel_q.pop_front();
                if (sel !== exp) begin
                    errors++;
                    $display("FAIL sel_value: got %b, expected %b", sel, exp);
                end
            end
            checks++;
            if (clk_en !== prev_clk_en) begin
                errors++;
                $display("FAIL sel_clk_en_same_cycle: clk_en %b -> %b while sel changed", prev_clk_en, clk_en);
            end
        end
        prev_sel    = sel;
        prev_clk_en = clk_en;
    end

    function automatic logic [7:0] bump(input logic [7:0] c);
`ifdef SPEED_CTRL_STATUS_EN
        return (c == 8'd255) ? c : c + 8'd1;
`else
        return 8'd0;
`endif
    endfunction

    task automatic wait_idle(input logic [1:0] target, input int limit, input string name);
        int n = 0;
        while (n < limit && !(busy === 1'b0 && sel === target)) begin
            @(negedge clk_100mhz);
            n++;
        end
        checks++;
        if (!(busy === 1'b0 && sel === target)) begin
            errors++;
            $display("FAIL %s: sel=%b busy=%b after %0d cycles, expected sel=%b busy=0",
                     name, sel, busy, n, target);
        end
    endtask

    task automatic test_reset();
        locked = 1'b1;
        sw     = 2'b00;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk_100mhz);
        checks++;
        if (sel !== 2'b00 || clk_en !== 1'b0 || busy !== 1'b1 || switch_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_values: sel=%b clk_en=%b busy=%b count=%0d, expected 00/0/1/0",
                     sel, clk_en, busy, switch_count);
        end
        rst = 1'b0;
        @(negedge clk_100mhz);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy_wait_lock: busy=%b, expected 1", busy);
        end
        wait_idle(2'b00, 20, "reset_to_run");
        checks++;
        if (clk_en !== 1'b0) begin
            errors++;
            $display("FAIL run_sel00_clk_en: clk_en=%b, expected 0", clk_en);
        end
    endtask

    task automatic test_switch();
        int n = 0;
        int m = 0;
        @(negedge clk_100mhz);
        sw = 2'b10;
        exp_sel_q.push_back(2'b10);
        exp_count = bump(exp_count);
        do begin
            @(negedge clk_100mhz);
            n++;
        end while (sel !== 2'b10 && n < 30);
        checks++;
        if (sel !== 2'b10 || n > 10) begin
            errors++;
            $display("FAIL switch_latency: sel=%b after %0d cycles, expected 10 within 10", sel, n);
        end
        do begin
            @(negedge clk_100mhz);
            m++;
        end while (clk_en !== 1'b1 && m < 20);
        checks++;
        if (m != SETTLE) begin
            errors++;
            $display("FAIL switch_clk_en_delay: clk_en rose %0d cycles after sel, expected %0d", m, SETTLE);
        end
        checks++;
        if (switch_count !== exp_count) begin
            errors++;
            $display("FAIL switch_count_first: got %0d, expected %0d", switch_count, exp_count);
        end
    endtask

    task automatic test_glitch();
        int drops = 0;
        @(negedge clk_100mhz);
        sw = 2'b11;
        repeat (3) @(negedge clk_100mhz);
        sw = 2'b10;
        repeat (20) begin
            @(negedge clk_100mhz);
            if (clk_en !== 1'b1) drops++;
        end
        checks++;
        if (drops != 0 || sel !== 2'b10) begin
            errors++;
            $display("FAIL glitch_rejected: clk_en low for %0d cycles, sel=%b, expected 0 and 10", drops, sel);
        end
    endtask

    task automatic test_lock_loss();
        int n = 0;
        int m = 0;
        @(negedge clk_100mhz);
        locked = 1'b0;
        do begin
            @(negedge clk_100mhz);
            n++;
            if (n == 1) locked = 1'b1;
        end while (clk_en !== 1'b0 && n < 10);
        checks++;
        if (clk_en !== 1'b0 || n > 3) begin
            errors++;
            $display("FAIL lock_loss_gate: clk_en=%b after %0d cycles, expected 0 within 3", clk_en, n);
        end
        checks++;
        if (sel !== 2'b10 || busy !== 1'b1) begin
            errors++;
            $display("FAIL lock_loss_hold: sel=%b busy=%b, expected 10 and 1", sel, busy);
        end
        do begin
            @(negedge clk_100mhz);
            m++;
        end while (clk_en !== 1'b1 && m < 20);
        checks++;
        if (m != 1 + SETTLE || busy !== 1'b0) begin
            errors++;
            $display("FAIL relock_settle: clk_en rose after %0d cycles busy=%b, expected %0d and 0",
                     m, busy, 1 + SETTLE);
        end
    endtask

    task automatic test_settle_retarget();
        int   n = 0;
        logic seen_low = 1'b0;
        logic early = 1'b0;
        @(negedge clk_100mhz);
        sw = 2'b01;
        exp_sel_q.push_back(2'b01);
        exp_count = bump(exp_count);
        wait_idle(2'b01, 40, "retarget_setup");
        sw = 2'b11;
        exp_sel_q.push_back(2'b11);
        exp_count = bump(exp_count);
        repeat (5) @(negedge clk_100mhz);
        sw = 2'b10;
        exp_sel_q.push_back(2'b10);
        exp_count = bump(exp_count);
        do begin
            @(negedge clk_100mhz);
            n++;
            if (clk_en === 1'b0) seen_low = 1'b1;
            if (seen_low && clk_en === 1'b1 && sel !== 2'b10) early = 1'b1;
        end while (!(sel === 2'b10 && busy === 1'b0) && n < 60);
        checks++;
        if (sel !== 2'b10 || clk_en !== 1'b1 || !seen_low || early) begin
            errors++;
            $display("FAIL settle_retarget: sel=%b clk_en=%b seen_low=%b early_rise=%b, expected 10/1/1/0",
                     sel, clk_en, seen_low, early);
        end
        checks++;
        if (switch_count !== exp_count) begin
            errors++;
            $display("FAIL settle_retarget_count: got %0d, expected %0d", switch_count, exp_count);
        end
    endtask

    task automatic test_reset_abort_and_saturation();
        int n = 0;
        @(negedge clk_100mhz);
        sw = 2'b01;
        do begin
            @(negedge clk_100mhz);
            n++;
        end while (clk_en !== 1'b0 && n < 20);
        #2;
        exp_sel_q.push_back(2'b00);
        rst = 1'b1;
        #1;
        checks++;
        if (sel !== 2'b00 || clk_en !== 1'b0 || busy !== 1'b1 || switch_count !== 8'd0) begin
            errors++;
            $display("FAIL async_reset_abort: sel=%b clk_en=%b busy=%b count=%0d, expected 00/0/1/0",
                     sel, clk_en, busy, switch_count);
        end
        exp_count = 8'd0;
        @(negedge clk_100mhz);
        @(negedge clk_100mhz);
        rst = 1'b0;
        exp_sel_q.push_back(2'b01);
        exp_count = bump(exp_count);
        wait_idle(2'b01, 60, "reenter_after_reset");
        checks++;
        if (switch_count !== exp_count) begin
            errors++;
            $display("FAIL count_after_reset: got %0d, expected %0d", switch_count, exp_count);
        end
        for (int i = 0; i < 256; i++) begin
            logic [1:0] target;
            target = (i % 2 == 0) ? 2'b10 : 2'b01;
            @(negedge clk_100mhz);
            sw = target;
            exp_sel_q.push_back(target);
            exp_count = bump(exp_count);
            wait_idle(target, 40, "forced_change");
        end
        checks++;
        if (switch_count !== exp_count) begin
            errors++;
            $display("FAIL count_saturation: got %0d, expected %0d", switch_count, exp_count);
        end
    endtask

    initial begin
        test_reset();
        test_switch();
        test_glitch();
        test_lock_loss();
        test_settle_retarget();
        test_reset_abort_and_saturation();
        repeat (4) @(negedge clk_100mhz);
        checks++;
        if (exp_sel_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drained: %0d sel changes never observed, expected 0", exp_sel_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
